// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported unified instruction/data RAM between the IF stage
// (instruction fetch) and the MEM stage (load/store) of the MIPS pipeline.
// An idle arbiter picks one requester per access. Data wins a simultaneous
// request unless the previous grant also went to data, so a steady load/store
// stream cannot starve instruction fetch. The winner's address, write data
// and write enable are latched and held on the RAM pins for MEM_LATENCY
// cycles. That is followed by a one-cycle DONE state carrying the ready pulse.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   if_req, if_addr        instruction fetch request and address
//   mem_r_en, mem_w_en     load / store request (both high means store)
//   mem_addr, mem_wdata    load/store address and store data
//   ram_rdata              RAM read data, valid in the last cycle of an access
//   ram_en, ram_we         RAM access active / write strobe
//   ram_addr, ram_wdata    RAM address / write data, held for the access
//   if_ready, if_rdata     fetch-complete pulse and registered instruction
//   mem_ready, mem_rdata   load/store-complete pulse and registered load data
//   freeze_if, freeze_mem  pipeline hold signals while an access is pending

module mem_port_arbiter #(
  parameter int MEM_LATENCY = 3,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] ram_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        freeze_if,
  output logic        freeze_mem
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } state_t;

  // Counter value seen during the final RAM cycle of an access
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant_d;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic             acc_we;
  logic             mem_req;
  logic             grant_d;
  logic             grant_i;
  logic             last_beat;

  assign mem_req   = mem_r_en | mem_w_en;
  assign last_beat = (cnt == LAST_CNT);

  // Arbitration is only evaluated in IDLE; nothing is granted in a DONE cycle.
  // On contention, data wins unless it also won last time (alternation).
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      if (mem_req && (!if_req || !last_grant_d)) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_i = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latched access parameters, latency counter and read-data capture.
  // Fetches latch a zero write word so the RAM write bus stays quiet.
  // A store leaves mem_rdata untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      last_grant_d <= 1'b0;
      acc_addr     <= '0;
      acc_wdata    <= '0;
      acc_we       <= 1'b0;
      if_rdata     <= '0;
      mem_rdata    <= '0;
    end else begin
      if (grant_d) begin
        acc_addr     <= mem_addr;
        acc_wdata    <= mem_wdata;
        acc_we       <= mem_w_en;
        cnt          <= '0;
        last_grant_d <= 1'b1;
      end else if (grant_i) begin
        acc_addr     <= if_addr;
        acc_wdata    <= '0;
        acc_we       <= 1'b0;
        cnt          <= '0;
        last_grant_d <= 1'b0;
      end else if (state == BUSY_I || state == BUSY_D) begin
        cnt <= cnt + 1'b1;
      end
      if (state == BUSY_I && last_beat) begin
        if_rdata <= ram_rdata;
      end
      if (state == BUSY_D && last_beat && !acc_we) begin
        mem_rdata <= ram_rdata;
      end
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          next_state = BUSY_D;
        end else if (grant_i) begin
          next_state = BUSY_I;
        end
      end
      BUSY_I: if (last_beat) next_state = DONE_I;
      BUSY_D: if (last_beat) next_state = DONE_D;
      DONE_I: next_state = IDLE;
      DONE_D: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: the RAM pins are driven only while an access is busy,
  // and show zero otherwise so an idle bus is unambiguous.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if_ready  = 1'b0;
    mem_ready = 1'b0;
    case (state)
      BUSY_I, BUSY_D: begin
        ram_en    = 1'b1;
        ram_we    = acc_we;
        ram_addr  = acc_addr;
        ram_wdata = acc_wdata;
      end
      DONE_I: if_ready = 1'b1;
      DONE_D: mem_ready = 1'b1;
      default: begin
      end
    endcase
  end

  // Freeze paths are combinational so the stalled stage releases in the same
  // cycle its ready pulse arrives.
  assign freeze_mem = mem_req & ~mem_ready;
  assign freeze_if  = freeze_mem | (if_req & ~if_ready);

endmodule
